sram_phy_sequencer: RTL
=======================

# sram_phy_sequencer

Responder end of the 32-bit SRAM command interface driven by the memory controller. It accepts one read or write command per `start` pulse and converts it into two 16-bit asynchronous-SRAM bus cycles on the board's 256K×16 (512 KB) device. Byte strobes are applied through UB/LB. It returns `done` with the assembled 32-bit read data.

## Interface

- `WAIT_CYCLES`, default 2: cycles the OE_n/WE_n strobe is held low per halfword; legal 1–15.
- `clk` in 1: system clock.
- `resetn` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle command request; honoured only in IDLE.
- `cmd` in 8: 0x01 read, 0x02 write, any other value is a no-op.
- `addr` in 32: byte address; bits [18:2] are used, all other bits are ignored.
- `wdata` in 32: write data.
- `wstrb` in 4: byte enables; bit n enables `wdata[8n+7:8n]`.
- `busy` out 1: transaction in progress.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: read result; held until the next read completes.
- `sram_a` out 18: SRAM halfword address.
- `sram_dq_out` out 16: write data to the pad.
- `sram_dq_oe` out 1: pad output enable.
- `sram_dq_in` in 16: read data from the pad.
- `sram_cs_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n` out 1 each: active-low SRAM controls.

## Operation

- Reset values: `busy` 0, `done` 0, `rdata` 0, `sram_a` 0, `sram_dq_out` 0, `sram_dq_oe` 0, all `*_n` outputs 1.
- States and transitions:
  - IDLE: on `start`, latch `cmd`/`addr`/`wdata`/`wstrb`.
  - Read or write → ADDR (low half).
  - Unknown cmd → DONE.
- ADDR, 1 cycle:
  - `sram_a` = {addr[18:2], half}; `cs_n` 0; `oe_n`/`we_n` 1.
  - Write: `dq_out` = selected half, `dq_oe` 1.
  - `ub_n` = !wstrb[2h+1], `lb_n` = !wstrb[2h]; reads drive both low.
- ACTIVE, WAIT_CYCLES cycles:
  - Read: `oe_n` 0; `sram_dq_in` is captured at the clock edge ending the last ACTIVE cycle, into rdata[15:0] (low) or rdata[31:16] (high).
  - Write: `we_n` 0.
- HOLD, 1 cycle: `oe_n`/`we_n` 1; address, byte enables and write data remain driven.
  - After the low half → ADDR (high half).
  - After the high half → DONE.
- DONE, 1 cycle: `done` 1, `cs_n` 1, `dq_oe` 0 → IDLE.
- `busy` is 1 from the cycle after `start` is accepted through the DONE cycle inclusive.
- `start` is ignored in every state other than IDLE, including DONE; no queuing.
- Writes and no-ops leave `rdata` unchanged.
- Reset mid-transaction: at the next edge all outputs return to reset values and the state goes to IDLE. The transaction is abandoned and `done` is not asserted.

## Timing

- Edge E0 samples `start`. Each halfword takes WAIT_CYCLES+2 cycles.
- Full read or write: `done` is high in cycle 2·(WAIT_CYCLES+2)+1 after E0. With WAIT_CYCLES=2, that is cycle 9.
- Single-half write (skip enabled): `done` in cycle WAIT_CYCLES+3, which is 5.
- No-op cmd, or a write with wstrb=0 and skip enabled: `done` in cycle 1, with no bus activity.
- Read data is valid on `rdata` in the same cycle `done` is high.
- `we_n` never falls in the same cycle that address or data change; ADDR and HOLD enforce setup and hold.

## Configuration

- `SRAM_SKIP_EMPTY_HALF_EN` defined: a write halfword whose two strobe bits are both 0 gets no bus cycle.
  - If only the high half is enabled, sequencing starts at ADDR (high half).
  - If wstrb=0, go directly to DONE.
- `SRAM_SKIP_EMPTY_HALF_EN` undefined: every write performs both halfword cycles. Disabled halves run with `ub_n`=`lb_n`=1, so memory is untouched and timing is constant.

## Test plan

- Reset: hold `resetn`=0 for 3 cycles → all outputs at reset values; `cs_n`=1, `dq_oe`=0.
- Full write then read, WAIT_CYCLES=2, against a behavioural SRAM model:
  - Write 0xDEADBEEF to 0x00000100, wstrb=F → `sram_a` 0x00080 with dq 0xBEEF, then 0x00081 with dq 0xDEAD; `done` at cycle 9.
  - Read 0x00000100 → `rdata`=0xDEADBEEF.
- Byte write, macro defined: wstrb=4'b0100, wdata=0x00AA0000 at 0x00000100 → one cycle at 0x00081 with `ub_n`=1, `lb_n`=0; `done` at cycle 5.
  - Readback → 0xDEAABEEF.
  - With the macro undefined: `done` at cycle 9 and the same readback.
- Protocol edges:
  - `start` re-pulsed at cycle 3 and in the DONE cycle → ignored; exactly one `done`.
  - cmd=0x07 → `done` at cycle 1, `cs_n` stays 1, `rdata` unchanged.
- Addressing: 0x0007FFFC → `sram_a` 0x3FFFE then 0x3FFFF; 0x00080000 → `sram_a` 0x00000 (upper bits ignored).
- Reset mid-write: `resetn`=0 at cycle 3 → `we_n`=1 and `cs_n`=1 at the next edge, no `done`; a subsequent read of another address completes normally.

Source files
------------

// File: rtl/sram_phy_sequencer.sv
// ---------------------------------------------------------------------------
// sram_phy_sequencer
//
// Responder for the memory controller's 32-bit SRAM command interface. Each
// accepted read or write command becomes two 16-bit asynchronous-SRAM bus
// cycles (low halfword first) on a 256Kx16 device. Every bus cycle runs
// ADDR -> ACTIVE (WAIT_CYCLES) -> HOLD, so WE_n/OE_n never move in the same
// cycle as the address, data or byte lanes.
//
// Optional build macro:
//   SRAM_SKIP_EMPTY_HALF_EN - write halfwords whose two byte strobes are
//                             both 0 get no bus cycle; a write with wstrb=0
//                             completes with no bus activity at all.
//
// Parameters:
//   WAIT_CYCLES  cycles OE_n/WE_n is held low per halfword (legal 1..15)
//
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   start, cmd           one-cycle request; cmd 0x01 read, 0x02 write,
//                        anything else completes as a no-op
//   addr, wdata, wstrb   byte address (bits [18:2] used), write data, byte
//                        enables
//   busy, done, rdata    transaction in progress, completion pulse, read
//                        result (held until the next read completes)
//   sram_a               SRAM halfword address
//   sram_dq_out/_oe/_in  data pad out, pad output enable, data pad in
//   sram_cs_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
//                        active-low SRAM controls
// ---------------------------------------------------------------------------
module sram_phy_sequencer #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [7:0]  cmd,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [17:0] sram_a,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_cs_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam logic [7:0] CMD_READ  = 8'h01;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    // The ACTIVE counter is loaded with WAIT_CYCLES-1 and ACTIVE ends when
    // it reaches zero.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ACTIVE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        half_q;
    logic        half_d;
    logic [3:0]  wait_cnt_q;
    logic        is_read_q;
    logic        is_write_q;
    logic [16:0] word_addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [15:0] rd_lo_q;
    logic [15:0] rd_hi_q;
    logic [31:0] rdata_q;

    // Address bits outside [18:2] do not reach the device.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:19], addr[1:0]};

    assign rdata = rdata_q;

    // State register: the current bus phase and which halfword it serves.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            half_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
        end
    end

    // Command latch, ACTIVE-phase counter and read-data capture. Each read
    // halfword is sampled on the edge that ends its last ACTIVE cycle; the
    // assembled word is published to rdata while the high-half HOLD cycle
    // ends, so rdata only changes as the read's done pulse appears.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wait_cnt_q  <= 4'd0;
            is_read_q   <= 1'b0;
            is_write_q  <= 1'b0;
            word_addr_q <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rd_lo_q     <= '0;
            rd_hi_q     <= '0;
            rdata_q     <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                is_read_q   <= (cmd == CMD_READ);
                is_write_q  <= (cmd == CMD_WRITE);
                word_addr_q <= addr[18:2];
                wdata_q     <= wdata;
                wstrb_q     <= wstrb;
            end

            if (state_q == S_ADDR) begin
                wait_cnt_q <= WAIT_LOAD;
            end else if (state_q == S_ACTIVE && wait_cnt_q != 4'd0) begin
                wait_cnt_q <= wait_cnt_q - 4'd1;
            end

            if (state_q == S_ACTIVE && wait_cnt_q == 4'd0 && is_read_q) begin
                if (half_q) begin
                    rd_hi_q <= sram_dq_in;
                end else begin
                    rd_lo_q <= sram_dq_in;
                end
            end

            if (state_q == S_HOLD && half_q && is_read_q) begin
                rdata_q <= {rd_hi_q, rd_lo_q};
            end
        end
    end

    // Next-state and output decode. Bus outputs are idle (reset values) in
    // IDLE and DONE; ADDR, ACTIVE and HOLD all drive the address, byte lanes
    // and write data so only OE_n/WE_n toggle between them. Reads enable
    // both byte lanes; writes map the strobe pair of the current halfword.
    always_comb begin
        state_d     = state_q;
        half_d      = half_q;
        busy        = (state_q != S_IDLE);
        done        = (state_q == S_DONE);
        sram_a      = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_cs_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_we_n   = 1'b1;
        sram_ub_n   = 1'b1;
        sram_lb_n   = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cmd == CMD_READ) begin
                        state_d = S_ADDR;
                        half_d  = 1'b0;
                    end else if (cmd == CMD_WRITE) begin
`ifdef SRAM_SKIP_EMPTY_HALF_EN
                        if (wstrb == 4'b0000) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_ADDR;
                            half_d  = (wstrb[1:0] == 2'b00);
                        end
`else
                        state_d = S_ADDR;
                        half_d  = 1'b0;
`endif
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_ADDR: begin
                state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (half_q) begin
                    state_d = S_DONE;
                end else begin
`ifdef SRAM_SKIP_EMPTY_HALF_EN
                    if (is_write_q && wstrb_q[3:2] == 2'b00) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ADDR;
                        half_d  = 1'b1;
                    end
`else
                    state_d = S_ADDR;
                    half_d  = 1'b1;
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_q == S_ADDR || state_q == S_ACTIVE || state_q == S_HOLD) begin
            sram_cs_n = 1'b0;
            sram_a    = {word_addr_q, half_q};
            if (is_write_q) begin
                sram_dq_out = half_q ? wdata_q[31:16] : wdata_q[15:0];
                sram_dq_oe  = 1'b1;
                sram_ub_n   = ~(half_q ? wstrb_q[3] : wstrb_q[1]);
                sram_lb_n   = ~(half_q ? wstrb_q[2] : wstrb_q[0]);
            end else begin
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
            end
            if (state_q == S_ACTIVE) begin
                sram_oe_n = ~is_read_q;
                sram_we_n = ~is_write_q;
            end
        end
    end

endmodule
